// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package muldiv_iter_pkg;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_IMUL = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_IDIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] f);
        return f[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] f);
        return f[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// trial subtraction for divide. Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum   = {1'b0, acc_i} + {1'b0, m_i & {WIDTH{mq_i[0]}}};
        trial = {acc_i, mq_i[WIDTH-1]};
        ge    = (trial >= {1'b0, m_i});
        // when the subtract succeeds the true difference is below m, so the
        // low WIDTH bits of a modulo subtraction are exact
        diff  = trial[WIDTH-1:0] - m_i;

        if (is_div_i) begin
            acc_o = ge ? diff : trial[WIDTH-1:0];
            mq_o  = {mq_i[WIDTH-2:0], ge};
        end else begin
            acc_o = sum[WIDTH:1];
            mq_o  = {sum[0], mq_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiplier/divider, one result bit per clock, for n-bit (word)
// or n/2-bit (byte) operands; signed forms run on magnitudes and fix up at the end.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// CALC  | K shift-add / trial-subtract iterations
// FIX   | sign fix-up, overflow flags, quotient range check
// DONE  | commit result; done pulses on the following cycle
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         func,
    input  logic               word_op,
    input  logic [2*WIDTH-1:0] x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               cfo,
    output logic               ofo,
    output logic               div_exc
);

    localparam int N  = WIDTH;
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    md_state_e state_q, state_d;

    logic [CW-1:0]  cnt_q;
    logic [1:0]     func_q;
    logic           word_q;
    logic           neg_res_q;
    logic           neg_rem_q;
    logic           ovf_q;
    logic [N-1:0]   acc_q;
    logic [N-1:0]   mq_q;
    logic [N-1:0]   m_q;
    logic [2*N-1:0] res_q;
    logic           flag_pend_q;
    logic           exc_pend_q;
    logic [2*N-1:0] out_q;
    logic           done_q;
    logic           cfo_q;
    logic           ofo_q;
    logic           div_exc_q;

    logic [2*N-1:0] x_raw, x_mask, x_mag;
    logic [N-1:0]   y_raw, y_mask, y_mag;
    logic           x_sign, y_sign, x_neg_in, y_neg_in, y_zero;
    logic [N-1:0]   acc_init, mq_init, m_init;
    logic [CW-1:0]  k_init;

    logic [N-1:0]   acc_nx, mq_nx;

    logic [2*N-1:0] prod_w, prod_w_s;
    logic [N-1:0]   prod_b, prod_b_s;
    logic [N-1:0]   qm, rm, q_s, r_s;
    logic           sovf;
    logic [2*N-1:0] fix_res;
    logic           fix_flag;
    logic           fix_exc;

    // operand preparation, only consumed on the accepted start edge
    always_comb begin
        x_raw  = '0;
        x_mask = '0;
        x_sign = 1'b0;
        case ({md_is_div(func), word_op})
            2'b11: begin
                x_raw  = x;
                x_mask = '1;
                x_sign = x[2*N-1];
            end
            2'b10, 2'b01: begin
                x_raw  = {{N{1'b0}}, x[N-1:0]};
                x_mask = {{N{1'b0}}, {N{1'b1}}};
                x_sign = x[N-1];
            end
            default: begin
                x_raw  = {{(2*N-H){1'b0}}, x[H-1:0]};
                x_mask = {{(2*N-H){1'b0}}, {H{1'b1}}};
                x_sign = x[H-1];
            end
        endcase

        y_raw    = word_op ? y : {{H{1'b0}}, y[H-1:0]};
        y_mask   = word_op ? {N{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
        y_sign   = word_op ? y[N-1] : y[H-1];
        y_zero   = (y_raw == '0);

        x_neg_in = md_is_signed(func) & x_sign;
        y_neg_in = md_is_signed(func) & y_sign;
        x_mag    = x_neg_in ? ((-x_raw) & x_mask) : x_raw;
        y_mag    = y_neg_in ? ((-y_raw) & y_mask) : y_raw;

        k_init   = word_op ? CW'(N) : CW'(H);

        if (md_is_div(func)) begin
            m_init   = y_mag;
            acc_init = word_op ? x_mag[2*N-1:N] : {{H{1'b0}}, x_mag[N-1:H]};
            mq_init  = word_op ? x_mag[N-1:0]   : {x_mag[H-1:0], {H{1'b0}}};
        end else begin
            m_init   = x_mag[N-1:0];
            acc_init = '0;
            mq_init  = y_mag;
        end
    end

    muldiv_step #(.WIDTH(N)) u_step (
        .is_div_i (md_is_div(func_q)),
        .acc_i    (acc_q),
        .mq_i     (mq_q),
        .m_i      (m_q),
        .acc_o    (acc_nx),
        .mq_o     (mq_nx)
    );

    // final fix-up from the magnitude results
    always_comb begin
        prod_w   = {acc_q, mq_q};
        prod_b   = {acc_q[H-1:0], mq_q[N-1:H]};
        prod_w_s = neg_res_q ? -prod_w : prod_w;
        prod_b_s = neg_res_q ? -prod_b : prod_b;

        qm   = word_q ? mq_q  : {{H{1'b0}}, mq_q[H-1:0]};
        rm   = word_q ? acc_q : {{H{1'b0}}, acc_q[H-1:0]};
        q_s  = neg_res_q ? -qm : qm;
        r_s  = neg_rem_q ? -rm : rm;
        // a negative quotient may reach -2^(k-1); a positive one stops at 2^(k-1)-1
        sovf = word_q ? (qm[N-1] & (~neg_res_q | (|qm[N-2:0])))
                      : (qm[H-1] & (~neg_res_q | (|qm[H-2:0])));

        fix_res  = '0;
        fix_flag = 1'b0;
        fix_exc  = 1'b0;
        if (md_is_div(func_q)) begin
            fix_res = word_q ? {r_s, q_s} : {{N{1'b0}}, r_s[H-1:0], q_s[H-1:0]};
            fix_exc = ovf_q | (md_is_signed(func_q) & sovf);
        end else if (word_q) begin
            fix_res  = prod_w_s;
            fix_flag = md_is_signed(func_q) ? (prod_w_s[2*N-1:N] != {N{prod_w_s[N-1]}})
                                            : (|prod_w_s[2*N-1:N]);
        end else begin
            fix_res  = {{N{1'b0}}, prod_b_s};
            fix_flag = md_is_signed(func_q) ? (prod_b_s[N-1:H] != {H{prod_b_s[H-1]}})
                                            : (|prod_b_s[N-1:H]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (md_is_div(func) && y_zero) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            func_q      <= MD_MUL;
            word_q      <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            mq_q        <= '0;
            m_q         <= '0;
            res_q       <= '0;
            flag_pend_q <= 1'b0;
            exc_pend_q  <= 1'b0;
            out_q       <= '0;
            done_q      <= 1'b0;
            cfo_q       <= 1'b0;
            ofo_q       <= 1'b0;
            div_exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        func_q      <= func;
                        word_q      <= word_op;
                        neg_res_q   <= x_neg_in ^ y_neg_in;
                        neg_rem_q   <= x_neg_in;
                        ovf_q       <= (acc_init >= m_init);
                        acc_q       <= acc_init;
                        mq_q        <= mq_init;
                        m_q         <= m_init;
                        cnt_q       <= k_init;
                        div_exc_q   <= 1'b0;
                        flag_pend_q <= 1'b0;
                        exc_pend_q  <= md_is_div(func) && y_zero;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_nx;
                    mq_q  <= mq_nx;
                    cnt_q <= cnt_q - CW'(1);
                end
                ST_FIX: begin
                    res_q       <= fix_res;
                    flag_pend_q <= fix_flag;
                    exc_pend_q  <= fix_exc;
                end
                ST_DONE: begin
                    done_q    <= 1'b1;
                    cfo_q     <= flag_pend_q;
                    ofo_q     <= flag_pend_q;
                    div_exc_q <= exc_pend_q;
                    if (!exc_pend_q) begin
                        out_q <= res_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out     = out_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cfo     = cfo_q;
    assign ofo     = ofo_q;
    assign div_exc = div_exc_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter (WIDTH=16): directed vectors push expected
// results, a done-triggered monitor pops and compares them.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst, start, word_op;
    logic [1:0]    func;
    logic [2*W-1:0] x, out;
    logic [W-1:0]  y;
    logic          busy, done, cfo, ofo, div_exc;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .func    (func),
        .word_op (word_op),
        .x       (x),
        .y       (y),
        .out     (out),
        .busy    (busy),
        .done    (done),
        .cfo     (cfo),
        .ofo     (ofo),
        .div_exc (div_exc)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        cf;
        logic        exc;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s.out", e.name), out, e.res);
                chk($sformatf("%s.cfo", e.name), {31'b0, cfo}, {31'b0, e.cf});
                chk($sformatf("%s.ofo", e.name), {31'b0, ofo}, {31'b0, e.cf});
                chk($sformatf("%s.div_exc", e.name), {31'b0, div_exc}, {31'b0, e.exc});
                chk($sformatf("%s.latency", e.name), cyc - e.t0, e.lat);
                chk($sformatf("%s.busy_in_done", e.name), {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] f, input logic w,
                         input logic [31:0] xv, input logic [15:0] yv,
                         input logic [31:0] eo, input logic ec, input logic ee,
                         input int lat, input int mid);
        exp_t n;
        @(negedge clk);
        start   = 1'b1;
        func    = f;
        word_op = w;
        x       = xv;
        y       = yv;
        n.name = nm; n.res = eo; n.cf = ec; n.exc = ee; n.lat = lat; n.t0 = cyc + 1;
        sb.push_back(n);
        @(negedge clk);
        start   = 1'b0;
        func    = ~f;
        word_op = ~w;
        x       = ~xv;
        y       = ~yv;
        chk($sformatf("%s.busy_after_start", nm), {31'b0, busy}, 32'd1);
        if (mid > 0) begin
            repeat (mid) @(negedge clk);
            start   = 1'b1;
            func    = MD_IDIV;
            word_op = 1'b0;
            x       = 32'h0000_0055;
            y       = 16'h0000;
            @(negedge clk);
            start   = 1'b0;
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout actual=no_done required=done", nm);
            sb.delete();
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; func = MD_MUL; word_op = 1'b0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        chk("reset.out", out, 32'd0);
        chk("reset.flags", {28'b0, busy, done, cfo, ofo}, 32'd0);
        chk("reset.div_exc", {31'b0, div_exc}, 32'd0);
        rst = 1'b0;

        issue("mul_w_ffff",   MD_MUL,  1'b1, 32'h0000_FFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 1'b0, 18, 0);
        issue("imul_b_m1x2",  MD_IMUL, 1'b0, 32'h0000_00FF, 16'h0002, 32'h0000_FFFE, 1'b0, 1'b0, 10, 0);
        issue("div_w_by3",    MD_DIV,  1'b1, 32'h0001_0000, 16'h0003, 32'h0001_5555, 1'b0, 1'b0, 18, 0);
        issue("idiv_b_m7",    MD_IDIV, 1'b0, 32'h0000_FFF9, 16'h0002, 32'h0000_FFFD, 1'b0, 1'b0, 10, 0);
        issue("div_w_zero",   MD_DIV,  1'b1, 32'h1234_5678, 16'h0000, 32'h0000_FFFD, 1'b0, 1'b1, 1,  0);
        issue("div_w_ovf",    MD_DIV,  1'b1, 32'h0002_0000, 16'h0001, 32'h0000_FFFD, 1'b0, 1'b1, 18, 0);
        issue("div_b_100_7",  MD_DIV,  1'b0, 32'h0000_0064, 16'h0007, 32'h0000_020E, 1'b0, 1'b0, 10, 0);
        issue("div_b_ovf",    MD_DIV,  1'b0, 32'h0000_0700, 16'h0007, 32'h0000_020E, 1'b0, 1'b1, 10, 0);
        issue("div_b_zero",   MD_DIV,  1'b0, 32'h0000_0700, 16'hFF00, 32'h0000_020E, 1'b0, 1'b1, 1,  0);
        issue("mul_b_200x3",  MD_MUL,  1'b0, 32'h0000_00C8, 16'hAB03, 32'h0000_0258, 1'b1, 1'b0, 10, 0);
        issue("imul_w_m2x3",  MD_IMUL, 1'b1, 32'h0000_FFFE, 16'h0003, 32'hFFFF_FFFA, 1'b0, 1'b0, 18, 0);
        issue("imul_w_ovf",   MD_IMUL, 1'b1, 32'h0000_4000, 16'h0004, 32'h0001_0000, 1'b1, 1'b0, 18, 0);
        issue("idiv_w_m7",    MD_IDIV, 1'b1, 32'hFFFF_FFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0, 1'b0, 18, 0);
        issue("idiv_w_7_m2",  MD_IDIV, 1'b1, 32'h0000_0007, 16'hFFFE, 32'h0001_FFFD, 1'b0, 1'b0, 18, 0);
        issue("idiv_w_pmax",  MD_IDIV, 1'b1, 32'h0000_8000, 16'h0001, 32'h0001_FFFD, 1'b0, 1'b1, 18, 0);
        issue("idiv_w_nmin",  MD_IDIV, 1'b1, 32'hFFFF_8000, 16'h0001, 32'h0000_8000, 1'b0, 1'b0, 18, 0);
        issue("mul_w_midst",  MD_MUL,  1'b1, 32'h0000_1234, 16'h0010, 32'h0001_2340, 1'b1, 1'b0, 18, 5);

        // reset coinciding with a start that would otherwise finish next cycle
        n0 = n_done;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; func = MD_DIV; word_op = 1'b1; x = 32'h1; y = 16'h0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start.busy", {31'b0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("rst_start.no_done", n_done, n0);

        // leave a nonzero result so the abort clearing is observable
        issue("mul_w_pre",    MD_MUL,  1'b1, 32'h0000_0101, 16'h0101, 32'h0001_0201, 1'b1, 1'b0, 18, 0);
        n0 = n_done;
        @(negedge clk);
        start = 1'b1; func = MD_MUL; word_op = 1'b1; x = 32'h0000_00FF; y = 16'h00FF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort.busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.out", out, 32'd0);
        chk("abort.flags", {27'b0, busy, done, cfo, ofo, div_exc}, 32'd0);
        repeat (25) @(negedge clk);
        chk("abort.no_done", n_done, n0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 Parameter: WIDTH, 16, full operand width n (even, >=8); half width h = WIDTH/2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 func  input  2  00 mul, 01 imul, 10 div, 11 idiv.
REQ-006 word_op  input  1  1 = n-bit operation, 0 = h-bit operation.
REQ-007 x  input  2*WIDTH  mul: multiplicand in x[n-1:0]; div: dividend (word: x[2n-1:0], byte: x[n-1:0]).
REQ-008 y  input  WIDTH  multiplier/divisor (byte: y[h-1:0]).
REQ-009 out  output  2*WIDTH  mul: product; div: {remainder, quotient} zero-extended to 2*WIDTH.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle completion pulse; out/flags valid from this cycle.
REQ-012 cfo, ofo  output  1 each  multiply overflow flags.
REQ-013 div_exc  output  1  divide error (zero divisor or quotient overflow); valid with done.

Function
REQ-014 States: IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX after K iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 K = n if word_op else h; iteration counter reloads at each accepted start.
REQ-016 Operands, func, word_op latched on the accepted start edge; later input changes have no effect.
REQ-017 start while busy is ignored, with no effect on the running operation.
REQ-018 done asserts exactly K+2 clocks after the start edge; busy high for exactly K+2 cycles, low in the done cycle.
REQ-019 div/idiv with zero divisor: IDLE->DONE directly; done 1 clock after start; div_exc=1; out holds its previous value.
REQ-020 Multiply: shift-add, one multiplier bit per cycle; imul on operand magnitudes, negated in FIX when signs differ.
REQ-021 Byte multiply result in out[n-1:0]; out[2n-1:n]=0.
REQ-022 mul: cfo=ofo=(upper half of product != 0); imul: cfo=ofo=(upper half != sign-extension of lower half).
REQ-023 Divide: restoring, one quotient bit per cycle; idiv on magnitudes; quotient truncates toward zero; remainder takes dividend's sign.
REQ-024 Quotient overflow is checked in FIX: div unsigned > 2^k-1; idiv outside [-2^(k-1), 2^(k-1)-1]; k = K; sets div_exc=1, out unchanged.
REQ-025 Divide results: cfo=ofo=0; div_exc=0 on success.
REQ-026 out, cfo, ofo, div_exc hold until the next accepted start completes.
REQ-027 div_exc clears on the next accepted start.

Reset
REQ-028 rst forces IDLE; out=0, busy=0, done=0, cfo=ofo=0, div_exc=0, counter=0.
REQ-029 rst during CALC/FIX/DONE aborts the operation; no done pulse follows.
REQ-030 rst together with start: reset wins; the start is dropped.

Structure
REQ-031 Shared package holds the func encodings (MD_MUL, MD_IMUL, MD_DIV, MD_IDIV) and the state enum.
REQ-032 One sub-module muldiv_step: combinational single iteration (add-or-pass for multiply, trial subtract for divide), WIDTH-parametrised.
REQ-033 No combinational path from inputs to outputs.

Verification (WIDTH=16)
REQ-034 mul word x=0xFFFF, y=0xFFFF -> out=0xFFFE0001, cfo=ofo=1, done 18 clocks after start.
REQ-035 imul byte x[7:0]=0xFF, y[7:0]=0x02 -> out=0x0000FFFE, cfo=ofo=0, done 10 clocks after start.
REQ-036 div word x=0x00010000, y=0x0003 -> out=0x00015555, div_exc=0; idiv byte x=0xFFF9, y=0x02 -> out[15:0]=0xFFFD.
REQ-037 div word y=0 -> div_exc=1, done 1 clock after start; div word x=0x00020000, y=0x0001 -> div_exc=1 at 18 clocks; out unchanged in both.
REQ-038 Second start pulsed mid-CALC -> ignored, first result correct; rst asserted mid-CALC -> IDLE, all outputs 0, no done pulse.
